// File: rtl/param_sync_fifo_pkg.sv
// Shared widths and read-mode constants for the single-clock FIFO.
package param_sync_fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Push/pop handshake, data and status bundle for param_sync_fifo.
interface param_sync_fifo_if
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = fifo_cnt_w(16)
);
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through reads,
// threshold flags, occupancy count and sticky error flags.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = MODE_STD,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  param_sync_fifo_if.slave bus
);

  localparam int ADDR_W = fifo_addr_w(DEPTH);
  localparam int CNT_W  = fifo_cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rd_word;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_q;
  logic              unf_q;

  // Acceptance uses pre-edge flags, so a full FIFO drops writes even when
  // a read frees a slot in the same cycle (and likewise for empty/read).
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_acc && !rd_acc)      count_q <= count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full)  ovf_q <= 1'b1;
      if (bus.rd_en && empty) unf_q <= 1'b1;
    end
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign bus.data_out   = rd_word;
      assign bus.data_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= rd_word;
        end
      end

      assign bus.data_out   = dout_q;
      assign bus.data_valid = valid_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: one standard-mode and one FWFT instance on a shared clock.
module tb_param_sync_fifo;
  import param_sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_W(8), .CNT_W(5)) bs ();
  param_sync_fifo_if #(.DATA_W(8), .CNT_W(5)) bf ();

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(MODE_STD),
                    .AF_THRESH(14), .AE_THRESH(2))
    u_std (.clk(clk), .rst(rst), .bus(bs));

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(MODE_FWFT),
                    .AF_THRESH(14), .AE_THRESH(2))
    u_fwft (.clk(clk), .rst(rst), .bus(bf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_std();
    bs.wr_en = 1'b0; bs.rd_en = 1'b0;
  endtask

  initial begin
    bs.wr_en = 1'b0; bs.rd_en = 1'b0; bs.data_in = '0;
    bf.wr_en = 1'b0; bf.rd_en = 1'b0; bf.data_in = '0;

    // Reset, with a write request that must be ignored
    rst = 1'b1;
    bs.wr_en = 1'b1; bs.data_in = 8'hEE;
    step(); step();
    bs.wr_en = 1'b0; rst = 1'b0;
    step();
    chk("rst_count",   32'(bs.count), 0);
    chk("rst_empty",   32'(bs.empty), 1);
    chk("rst_ae",      32'(bs.almost_empty), 1);
    chk("rst_full",    32'(bs.full), 0);
    chk("rst_af",      32'(bs.almost_full), 0);
    chk("rst_dv",      32'(bs.data_valid), 0);
    chk("rst_dout",    32'(bs.data_out), 0);
    chk("rst_ovf",     32'(bs.overflow), 0);
    chk("rst_unf",     32'(bs.underflow), 0);
    chk("rst_f_empty", 32'(bf.empty), 1);
    chk("rst_f_dv",    32'(bf.data_valid), 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      bs.wr_en = 1'b1; bs.data_in = 8'(i);
      step();
      chk("fill_count", 32'(bs.count), 32'(i + 1));
      chk("fill_af",    32'(bs.almost_full), (i + 1 >= 14) ? 1 : 0);
      chk("fill_ae",    32'(bs.almost_empty), (i + 1 <= 2) ? 1 : 0);
    end
    chk("fill_full", 32'(bs.full), 1);
    bs.data_in = 8'hFF;
    step();
    idle_std();
    chk("ovf_set",   32'(bs.overflow), 1);
    chk("ovf_count", 32'(bs.count), 16);

    // Read back with gaps to see each data_valid pulse
    for (int i = 0; i < 16; i++) begin
      bs.rd_en = 1'b1;
      step();
      chk("rd_dout", 32'(bs.data_out), 32'(i));
      chk("rd_dv",   32'(bs.data_valid), 1);
      chk("rd_count", 32'(bs.count), 32'(15 - i));
      bs.rd_en = 1'b0;
      step();
      chk("rd_dv_pulse", 32'(bs.data_valid), 0);
      chk("rd_hold",     32'(bs.data_out), 32'(i));
    end
    chk("drain_empty", 32'(bs.empty), 1);
    chk("drain_unf0",  32'(bs.underflow), 0);
    bs.rd_en = 1'b1;
    step();
    bs.rd_en = 1'b0;
    chk("unf_set",  32'(bs.underflow), 1);
    chk("unf_dv",   32'(bs.data_valid), 0);
    chk("unf_hold", 32'(bs.data_out), 32'h0F);

    // Simultaneous push/pop at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      bs.wr_en = 1'b1; bs.data_in = 8'(8'h20 + i);
      step();
    end
    chk("sim_pre_count", 32'(bs.count), 5);
    for (int i = 0; i < 40; i++) begin
      bs.wr_en = 1'b1; bs.rd_en = 1'b1; bs.data_in = 8'(8'h25 + i);
      step();
      chk("sim_count", 32'(bs.count), 5);
      chk("sim_dout",  32'(bs.data_out), 32'(8'(8'h20 + i)));
    end
    idle_std();

    // Simultaneous at count=0 and count=16
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_count", 32'(bs.count), 0);
    chk("rst2_dout",  32'(bs.data_out), 0);
    chk("rst2_unf",   32'(bs.underflow), 0);
    bs.wr_en = 1'b1; bs.rd_en = 1'b1; bs.data_in = 8'h77;
    step();
    idle_std();
    chk("sim0_count", 32'(bs.count), 1);
    chk("sim0_dv",    32'(bs.data_valid), 0);
    chk("sim0_unf",   32'(bs.underflow), 1);
    for (int i = 0; i < 15; i++) begin
      bs.wr_en = 1'b1; bs.data_in = 8'(8'h78 + i);
      step();
    end
    chk("sim16_pre", 32'(bs.count), 16);
    bs.wr_en = 1'b1; bs.rd_en = 1'b1; bs.data_in = 8'h99;
    step();
    idle_std();
    chk("sim16_count", 32'(bs.count), 15);
    chk("sim16_ovf",   32'(bs.overflow), 1);
    chk("sim16_dout",  32'(bs.data_out), 32'h77);
    chk("sim16_dv",    32'(bs.data_valid), 1);

    // FWFT instance
    bf.wr_en = 1'b1; bf.data_in = 8'hA5;
    step();
    bf.wr_en = 1'b0;
    chk("fw_dout",  32'(bf.data_out), 32'hA5);
    chk("fw_dv",    32'(bf.data_valid), 1);
    chk("fw_empty", 32'(bf.empty), 0);
    bf.rd_en = 1'b1;
    step();
    bf.rd_en = 1'b0;
    chk("fw_pop_empty", 32'(bf.empty), 1);
    chk("fw_pop_dv",    32'(bf.data_valid), 0);
    bf.wr_en = 1'b1; bf.data_in = 8'h11; step();
    bf.data_in = 8'h22; step();
    bf.wr_en = 1'b0;
    chk("fw_head1", 32'(bf.data_out), 32'h11);
    bf.rd_en = 1'b1; step();
    bf.rd_en = 1'b0;
    chk("fw_head2", 32'(bf.data_out), 32'h22);
    chk("fw_cnt1",  32'(bf.count), 1);

    // Mid-operation reset at count=9 with overflow set
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bs.wr_en = 1'b1; bs.data_in = 8'(8'h40 + i);
      step();
    end
    idle_std();
    for (int i = 0; i < 7; i++) begin
      bs.rd_en = 1'b1; step();
    end
    idle_std();
    chk("mid_pre_count", 32'(bs.count), 9);
    chk("mid_pre_ovf",   32'(bs.overflow), 1);
    rst = 1'b1; bs.rd_en = 1'b1;
    step();
    rst = 1'b0; bs.rd_en = 1'b0;
    chk("mid_count", 32'(bs.count), 0);
    chk("mid_empty", 32'(bs.empty), 1);
    chk("mid_ovf",   32'(bs.overflow), 0);
    chk("mid_dv",    32'(bs.data_valid), 0);
    bs.wr_en = 1'b1; bs.data_in = 8'h5A; step();
    bs.wr_en = 1'b0; bs.rd_en = 1'b1; step();
    bs.rd_en = 1'b0;
    chk("mid_new_dout", 32'(bs.data_out), 32'h5A);
    chk("mid_new_dv",   32'(bs.data_valid), 1);
    chk("mid_new_empty", 32'(bs.empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
